// File: rtl/codel_drop_ctrl.sv
// CoDel drop-state controller: per-dequeue drop decision with interval/sqrt(count) law.
// Latency 1 cycle (registered decision and state); accepts a dequeue every cycle, never backpressures.

package CodelPkg;
  typedef logic [31:0] TimeCtr;
endpackage

module codel_drop_ctrl
  import CodelPkg::*;
#(
  parameter int COUNT_W    = 16,
  parameter int LUT_DEPTH  = 64,
  parameter int RECIP_FRAC = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i__deq_valid,
  input  logic               i__okay_to_drop,
  input  TimeCtr             i__time_counter,
  input  TimeCtr             i__interval,
  output logic               o__drop_valid,
  output logic               o__drop,
  output logic               o__dropping,
  output logic [COUNT_W-1:0] o__count,
  output TimeCtr             o__drop_next
);

  localparam int TW = $bits(TimeCtr);
  localparam int RW = RECIP_FRAC + 1;
  localparam int IW = $clog2(LUT_DEPTH + 1);
  localparam int PW = TW + RW;

  typedef enum logic {IDLE, DROPPING} state_t;

  // Largest r with r*r*n <= 2^(2*RECIP_FRAC), i.e. floor(2^RECIP_FRAC / sqrt(n)).
  function automatic logic [RW-1:0] recip_sqrt(input longint unsigned n);
    longint unsigned r;
    longint unsigned t;
    longint unsigned lim;
    r   = 64'd0;
    lim = 64'd1 << (2 * RECIP_FRAC);
    for (int b = RW - 1; b >= 0; b--) begin
      t = r | (64'd1 << b);
      if (t * t * n <= lim) r = t;
    end
    return r[RW-1:0];
  endfunction

  logic [RW-1:0] rom [0:LUT_DEPTH];
  assign rom[0] = '0;
  for (genvar g = 1; g <= LUT_DEPTH; g++) begin : g_rom
    assign rom[g] = recip_sqrt(64'(g));
  end

  state_t             state, state_nxt;
  logic [COUNT_W-1:0] count, count_nxt, count_inc, count_re, law_count;
  TimeCtr             drop_next, drop_next_nxt, since_next, law;
  logic               drop_nxt;
  logic [IW-1:0]      rom_idx;
  logic [PW-1:0]      product;

  assign count_inc = (&count) ? count : count + COUNT_W'(1);
  assign since_next = i__time_counter - drop_next;
  // Re-entering soon after leaving resumes near the previous drop rate.
  assign count_re = (since_next < i__interval) ?
                    ((count > COUNT_W'(2)) ? count - COUNT_W'(2) : COUNT_W'(1)) :
                    COUNT_W'(1);
  assign law_count = (state == DROPPING) ? count_inc : count_re;
  assign rom_idx = (law_count >= COUNT_W'(LUT_DEPTH)) ? IW'(LUT_DEPTH) : law_count[IW-1:0];
  assign product = PW'(i__interval) * PW'(rom[rom_idx]);
  assign law = TW'(product >> RECIP_FRAC);

  always_comb begin
    state_nxt     = state;
    count_nxt     = count;
    drop_next_nxt = drop_next;
    drop_nxt      = 1'b0;
    if (i__deq_valid) begin
      case (state)
        IDLE: begin
          if (i__okay_to_drop) begin
            drop_nxt      = 1'b1;
            state_nxt     = DROPPING;
            count_nxt     = count_re;
            drop_next_nxt = i__time_counter + law;
          end
        end
        DROPPING: begin
          if (!i__okay_to_drop) begin
            state_nxt = IDLE;
          end else if (i__time_counter >= drop_next) begin
            drop_nxt      = 1'b1;
            count_nxt     = count_inc;
            drop_next_nxt = drop_next + law;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      count         <= '0;
      drop_next     <= '0;
      o__drop_valid <= 1'b0;
      o__drop       <= 1'b0;
    end else begin
      state         <= state_nxt;
      count         <= count_nxt;
      drop_next     <= drop_next_nxt;
      o__drop_valid <= i__deq_valid;
      o__drop       <= drop_nxt;
    end
  end

  assign o__dropping  = (state == DROPPING);
  assign o__count     = count;
  assign o__drop_next = drop_next;

endmodule

// File: tb/tb_codel_drop_ctrl.sv
// Scoreboarded bench for codel_drop_ctrl: directed test-plan cases plus random traffic vs a spec-level model.
module tb_codel_drop_ctrl;
  import CodelPkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i__deq_valid = 1'b0;
  logic        i__okay_to_drop = 1'b0;
  TimeCtr      i__time_counter = '0;
  TimeCtr      i__interval = '0;
  logic        o__drop_valid;
  logic        o__drop;
  logic        o__dropping;
  logic [15:0] o__count;
  TimeCtr      o__drop_next;

  codel_drop_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .i__deq_valid    (i__deq_valid),
    .i__okay_to_drop (i__okay_to_drop),
    .i__time_counter (i__time_counter),
    .i__interval     (i__interval),
    .o__drop_valid   (o__drop_valid),
    .o__drop         (o__drop),
    .o__dropping     (o__dropping),
    .o__count        (o__count),
    .o__drop_next    (o__drop_next)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          vld;
    bit          drop;
    bit          dropping;
    int unsigned count;
    TimeCtr      dnext;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   passed = 0;

  // Reference model state
  bit          m_dropping = 1'b0;
  int unsigned m_count = 0;
  TimeCtr      m_next = '0;
  int unsigned rom_m [1:64];

  localparam TimeCtr TMAX = 32'hFFFF_FFFF;

  function automatic TimeCtr law_m(int unsigned n, TimeCtr intv);
    int unsigned     k;
    longint unsigned p;
    k = (n > 64) ? 64 : n;
    p = 64'(intv) * 64'(rom_m[k]);
    return 32'(p >> 16);
  endfunction

  task automatic chk(string nm, longint unsigned act, longint unsigned exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  task automatic step(bit rst, bit dv, bit ok, TimeCtr now, TimeCtr intv);
    exp_t   e;
    bit     drop;
    TimeCtr diff;
    reset           = rst;
    i__deq_valid    = dv;
    i__okay_to_drop = ok;
    i__time_counter = now;
    i__interval     = intv;
    @(posedge clk);
    drop = 1'b0;
    if (rst) begin
      m_dropping = 1'b0;
      m_count    = 0;
      m_next     = '0;
    end else if (dv) begin
      if (!m_dropping && ok) begin
        diff = now - m_next;
        if (diff < intv) m_count = (m_count > 2) ? m_count - 2 : 1;
        else m_count = 1;
        m_dropping = 1'b1;
        m_next     = now + law_m(m_count, intv);
        drop       = 1'b1;
      end else if (m_dropping && !ok) begin
        m_dropping = 1'b0;
      end else if (m_dropping && now >= m_next) begin
        if (m_count < 65535) m_count++;
        m_next = m_next + law_m(m_count, intv);
        drop   = 1'b1;
      end
    end
    e.vld      = dv && !rst;
    e.drop     = drop;
    e.dropping = m_dropping;
    e.count    = m_count;
    e.dnext    = m_next;
    sbq.push_back(e);
    #1;
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      chk("drop_valid", 64'(o__drop_valid), 64'(e.vld));
      chk("drop",       64'(o__drop),       64'(e.drop));
      chk("dropping",   64'(o__dropping),   64'(e.dropping));
      chk("count",      64'(o__count),      64'(e.count));
      chk("drop_next",  64'(o__drop_next),  64'(e.dnext));
    end
  end

  initial begin
    TimeCtr now;
    for (int n = 1; n <= 64; n++) rom_m[n] = $rtoi(65536.0 / $sqrt(real'(n)));

    // Reset with random inputs applied
    step(1, 1'($urandom), 1'($urandom), $urandom, $urandom);
    step(1, 1'($urandom), 1'($urandom), $urandom, $urandom);

    // Directed control-law sequence
    step(0, 1, 1, 1000, 100);
    step(0, 1, 1, 1050, 100);
    step(0, 1, 1, 1100, 100);
    step(0, 1, 0, 1110, 100);
    step(0, 1, 1, 1200, 100);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 1300 + i * 10, 100);

    // Reset while dropping with a concurrent dequeue
    step(1, 1, 1, 1400, 100);

    // Random traffic
    now = 32'd2000;
    for (int i = 0; i < 400; i++) begin
      now = now + $urandom_range(0, 40);
      step(($urandom_range(0, 63) == 0), 1'($urandom), ($urandom_range(0, 9) < 7),
           now, $urandom_range(50, 500));
    end

    // Build count to 100, then hit drop_next exactly with interval 800
    step(1, 0, 0, 0, 100);
    step(0, 1, 1, TMAX, 100);
    for (int i = 0; i < 99; i++) step(0, 1, 1, TMAX, 100);
    if (m_next != 0) step(0, 1, 1, m_next - 1, 800);
    step(0, 1, 1, m_next, 800);

    // Drive count into saturation and beyond
    for (int i = 0; i < 65440; i++) step(0, 1, 1, TMAX, 800);

    step(0, 0, 0, 0, 100);
    repeat (3) @(negedge clk);
    if (sbq.size() != 0) begin
      checks++;
      $display("FAIL drain: %0d entries left, expected 0", sbq.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
